// File: rtl/scroll_controller.sv
// Road scroll sequencer: per-frame speed FSM and vertical scroll offset.
// All state advances only at the last pixel of a frame so the road never tears.
module scroll_controller #(
    parameter int H_LAST       = 799,
    parameter int V_LAST       = 524,
    parameter int OFFSET_W     = 6,
    parameter int MAX_SPEED    = 7,
    parameter int ACCEL_FRAMES = 8,
    parameter int BRAKE_FRAMES = 4,
    parameter int COAST_FRAMES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [9:0]          pixel_x,
    input  logic [9:0]          pixel_y,
    input  logic                accel,
    input  logic                brake,
    input  logic                pause,
    output logic [OFFSET_W-1:0] scroll_offset,
    output logic [2:0]          speed,
    output logic                frame_tick,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        STOPPED = 2'b00,
        ACCEL   = 2'b01,
        CRUISE  = 2'b10,
        BRAKE   = 2'b11
    } state_t;

    localparam int LIM_AB  = (ACCEL_FRAMES > BRAKE_FRAMES) ?
                             ACCEL_FRAMES : BRAKE_FRAMES;
    localparam int LIM_MAX = (LIM_AB > COAST_FRAMES) ?
                             LIM_AB : COAST_FRAMES;
    localparam int FCNT_W  = ($clog2(LIM_MAX) > 0) ?
                             $clog2(LIM_MAX) : 1;

    localparam logic [FCNT_W-1:0] ACCEL_LAST = FCNT_W'(ACCEL_FRAMES - 1);
    localparam logic [FCNT_W-1:0] BRAKE_LAST = FCNT_W'(BRAKE_FRAMES - 1);
    localparam logic [FCNT_W-1:0] COAST_LAST = FCNT_W'(COAST_FRAMES - 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE   = FCNT_W'(1);
    localparam logic [2:0]        SPD_MAX    = 3'(MAX_SPEED);

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          speed_q;
    logic [2:0]          speed_d;
    logic [2:0]          speed_inc;
    logic [2:0]          speed_dec;
    logic [FCNT_W-1:0]   fcnt_q;
    logic [FCNT_W-1:0]   fcnt_d;
    logic [OFFSET_W-1:0] offset_q;
    logic                tick_q;
    logic                eof;
    logic                update;

    assign eof    = (pixel_x == 10'(H_LAST)) && (pixel_y == 10'(V_LAST));
    assign update = eof && !pause;

    // Saturating neighbours of the current speed
    assign speed_inc = (speed_q < SPD_MAX) ? speed_q + 3'd1 : SPD_MAX;
    assign speed_dec = (speed_q != 3'd0) ? speed_q - 3'd1 : 3'd0;

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        fcnt_d  = fcnt_q + FCNT_ONE;
        unique case (state_q)
            STOPPED: begin
                speed_d = 3'd0;
                fcnt_d  = '0;
                if (!brake && accel) begin
                    state_d = ACCEL;
                end
            end
            ACCEL: begin
                if (brake) begin
                    state_d = BRAKE;
                    fcnt_d  = '0;
                end else if (accel) begin
                    if (fcnt_q == ACCEL_LAST) begin
                        fcnt_d  = '0;
                        speed_d = speed_inc;
                    end
                end else begin
                    state_d = CRUISE;
                    fcnt_d  = '0;
                end
            end
            CRUISE: begin
                if (brake) begin
                    state_d = BRAKE;
                    fcnt_d  = '0;
                end else if (accel) begin
                    state_d = ACCEL;
                    fcnt_d  = '0;
                end else if (fcnt_q == COAST_LAST) begin
                    fcnt_d  = '0;
                    speed_d = speed_dec;
                    if (speed_dec == 3'd0) begin
                        state_d = STOPPED;
                    end
                end else if (speed_q == 3'd0) begin
                    state_d = STOPPED;
                    fcnt_d  = '0;
                end
            end
            BRAKE: begin
                if (brake) begin
                    if (fcnt_q == BRAKE_LAST) begin
                        fcnt_d  = '0;
                        speed_d = speed_dec;
                        if (speed_dec == 3'd0) begin
                            state_d = STOPPED;
                        end
                    end else if (speed_q == 3'd0) begin
                        state_d = STOPPED;
                        fcnt_d  = '0;
                    end
                end else if (accel) begin
                    state_d = ACCEL;
                    fcnt_d  = '0;
                end else begin
                    state_d = (speed_q == 3'd0) ? STOPPED : CRUISE;
                    fcnt_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= STOPPED;
            speed_q  <= 3'd0;
            fcnt_q   <= '0;
            offset_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= eof;
            // Offset advances by the speed held before this frame boundary
            if (update) begin
                state_q  <= state_d;
                speed_q  <= speed_d;
                fcnt_q   <= fcnt_d;
                offset_q <= offset_q + OFFSET_W'(speed_q);
            end
        end
    end

    assign scroll_offset = offset_q;
    assign speed         = speed_q;
    assign frame_tick    = tick_q;
    assign state         = state_q;

endmodule

// File: tb/tb_scroll_controller.sv
// Directed bench for scroll_controller with a short 10x5 frame.
// Expected offsets/speeds are hand-derived per end-of-frame.
module tb_scroll_controller;

    localparam int H_LAST = 9;
    localparam int V_LAST = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       accel;
    logic       brake;
    logic       pause;
    logic [5:0] scroll_offset;
    logic [2:0] speed;
    logic       frame_tick;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // accel held from STOPPED, eofs 1..25
    int b_spd [25] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6,
                       7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    int b_off [25] = '{0, 0, 0, 1, 2, 4, 6, 9, 12, 16, 20, 25, 30,
                       36, 42, 49, 56, 63, 6, 13, 20, 27, 34, 41, 48};
    // accel+brake together, eofs 26..35
    int d_spd [10] = '{7, 6, 5, 4, 3, 2, 1, 0, 0, 0};
    int d_off [10] = '{55, 62, 4, 9, 13, 16, 18, 19, 19, 19};
    int d_st  [10] = '{3, 3, 3, 3, 3, 3, 3, 0, 0, 0};
    // accel to speed 3 then coast, eofs 36..45
    int e_spd [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
    int e_off [10] = '{19, 19, 19, 20, 21, 23, 25, 28, 31, 34};
    int e_st  [10] = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 2};
    // coast after pause, eofs 46..56
    int f_spd [11] = '{3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0};
    int f_off [11] = '{37, 40, 42, 44, 46, 48, 49, 50, 51, 52, 52};
    int f_st  [11] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 0, 0};
    // restart from STOPPED, eofs 57..60
    int g_spd [4] = '{0, 0, 1, 1};
    int g_off [4] = '{52, 52, 52, 53};

    scroll_controller #(
        .H_LAST(H_LAST),
        .V_LAST(V_LAST),
        .OFFSET_W(6),
        .MAX_SPEED(7),
        .ACCEL_FRAMES(2),
        .BRAKE_FRAMES(1),
        .COAST_FRAMES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .accel(accel),
        .brake(brake),
        .pause(pause),
        .scroll_offset(scroll_offset),
        .speed(speed),
        .frame_tick(frame_tick),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_eof(input string tag, input int off,
                              input int spd, input int st);
        chk({tag, "_off"}, 8'(scroll_offset), 8'(off));
        chk({tag, "_spd"}, 8'(speed), 8'(spd));
        chk({tag, "_st"}, 8'(state), 8'(st));
        chk({tag, "_tick"}, 8'(frame_tick), 8'd1);
    endtask

    // Scans rows 0..y_last, starting and ending on a negedge; checks the
    // tick is a single cycle right after eof and outputs hold elsewhere.
    task automatic run_frame(input string tag, input int y_last);
        logic [5:0] off0;
        logic [2:0] spd0;
        logic [1:0] st0;
        int         bad;
        bit         last;
        off0 = scroll_offset;
        spd0 = speed;
        st0  = state;
        bad  = 0;
        for (int y = 0; y <= y_last; y++) begin
            for (int x = 0; x <= H_LAST; x++) begin
                pixel_x = 10'(x);
                pixel_y = 10'(y);
                @(negedge clk);
                last = (x == H_LAST) && (y == V_LAST);
                if (frame_tick !== last) bad++;
                if (!last && (scroll_offset !== off0 ||
                              speed !== spd0 || state !== st0)) bad++;
            end
        end
        chk({tag, "_shape"}, 8'(bad), 8'd0);
    endtask

    initial begin
        pixel_x = 10'd5;
        pixel_y = 10'd2;
        accel   = 1'b0;
        brake   = 1'b0;
        pause   = 1'b0;

        #2 reset = 1'b0;
        #1;
        chk("rst0_off", 8'(scroll_offset), 8'd0);
        chk("rst0_spd", 8'(speed), 8'd0);
        chk("rst0_st", 8'(state), 8'd0);
        chk("rst0_tick", 8'(frame_tick), 8'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_frame("idle", V_LAST);
            expect_eof("idle", 0, 0, 0);
        end

        accel = 1'b1;
        for (int i = 0; i < 25; i++) begin
            run_frame("acc", V_LAST);
            expect_eof($sformatf("acc%0d", i + 1), b_off[i], b_spd[i], 1);
        end

        brake = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_frame("brk", V_LAST);
            expect_eof($sformatf("brk%0d", i + 26), d_off[i], d_spd[i],
                       d_st[i]);
        end

        brake = 1'b0;
        for (int i = 0; i < 10; i++) begin
            accel = (i < 7);
            run_frame("up", V_LAST);
            expect_eof($sformatf("up%0d", i + 36), e_off[i], e_spd[i],
                       e_st[i]);
        end

        pause = 1'b1;
        brake = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_frame("pause", V_LAST);
            expect_eof($sformatf("pause%0d", i), 34, 3, 2);
        end
        pause = 1'b0;
        brake = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_frame("coast", V_LAST);
            expect_eof($sformatf("coast%0d", i + 46), f_off[i], f_spd[i],
                       f_st[i]);
        end

        accel = 1'b1;
        run_frame("skip", V_LAST - 1);
        chk("skip_st", 8'(state), 8'd0);
        chk("skip_off", 8'(scroll_offset), 8'd52);

        for (int i = 0; i < 4; i++) begin
            run_frame("re", V_LAST);
            expect_eof($sformatf("re%0d", i + 57), g_off[i], g_spd[i], 1);
        end

        reset = 1'b0;
        #1;
        chk("rst1_off", 8'(scroll_offset), 8'd0);
        chk("rst1_spd", 8'(speed), 8'd0);
        chk("rst1_st", 8'(state), 8'd0);
        chk("rst1_tick", 8'(frame_tick), 8'd0);
        @(negedge clk);
        reset = 1'b1;
        accel = 1'b0;
        run_frame("post", V_LAST);
        expect_eof("post", 0, 0, 0);
        accel = 1'b1;
        run_frame("post_acc", V_LAST);
        expect_eof("post_acc", 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
